// File: rtl/accum_pkg.sv
// Shared types and saturation limits for the accumulate-and-saturate stage.
package accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Limits are returned wide so callers can size-cast them to N or N+1 bits.
    function automatic longint sat_max(input int n);
        return (longint'(1) <<< (n - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int n);
        return -(longint'(1) <<< (n - 1));
    endfunction

endpackage

// File: rtl/accum_sat_stage_if.sv
// Sample-in / result-out handshake bundle for accum_sat_stage.
interface accum_sat_stage_if #(
    parameter int N = 8
);
    logic                in_valid;
    logic                in_ready;
    logic signed [N-1:0] in_data;
    logic                in_ovf;
    logic                out_valid;
    logic                out_ready;
    logic signed [N-1:0] out_data;
    logic                out_sat;

    modport master (
        output in_valid, in_data, in_ovf, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_ovf, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/sat_add.sv
// Combinational signed N-bit add with clamping to the N-bit two's complement range.
module sat_add
    import accum_pkg::*;
#(
    parameter int N = 8
) (
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    output logic signed [N-1:0] sum,
    output logic                clamp
);

    localparam logic signed [N:0] MAX_W = (N+1)'(sat_max(N));
    localparam logic signed [N:0] MIN_W = (N+1)'(sat_min(N));

    logic signed [N:0] wide;

    function automatic logic signed [N-1:0] saturate(input logic signed [N:0] s);
        logic signed [N-1:0] r;
        if (s > MAX_W) begin
            r = MAX_W[N-1:0];
        end else if (s < MIN_W) begin
            r = MIN_W[N-1:0];
        end else begin
            r = s[N-1:0];
        end
        return r;
    endfunction

    function automatic logic out_of_range(input logic signed [N:0] s);
        return (s > MAX_W) || (s < MIN_W);
    endfunction

    // One guard bit is enough: the sum of two N-bit values always fits in N+1.
    assign wide  = {a[N-1], a} + {b[N-1], b};
    assign sum   = saturate(wide);
    assign clamp = out_of_range(wide);

endmodule

// File: rtl/accum_sat_stage.sv
// Block accumulator: sums len samples with saturation, then presents one sticky-flagged result.
module accum_sat_stage
    import accum_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic             busy,
    accum_sat_stage_if.slave bus
);

    state_t              state;
    logic signed [N-1:0] acc;
    logic [CNT_W-1:0]    cnt;
    logic                sticky;
    logic signed [N-1:0] out_data_r;
    logic                out_sat_r;

    logic signed [N-1:0] sum_w;
    logic                clamp_w;
    logic                in_ready_w;
    logic                beat;
    logic                flag_w;
    logic                last_beat;

    sat_add #(.N(N)) u_sat_add (
        .a     (acc),
        .b     (bus.in_data),
        .sum   (sum_w),
        .clamp (clamp_w)
    );

    // in_ready depends on state alone so upstream never sees a path from in_valid.
    assign in_ready_w = (state == ACCUM);
    assign beat       = bus.in_valid && in_ready_w;
    assign flag_w     = sticky | clamp_w | bus.in_ovf;
    assign last_beat  = (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            sticky     <= 1'b0;
            out_data_r <= '0;
            out_sat_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (len != '0)) begin
                        acc    <= '0;
                        sticky <= 1'b0;
                        cnt    <= len;
                        state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc    <= sum_w;
                        sticky <= flag_w;
                        cnt    <= cnt - CNT_W'(1);
                        if (last_beat) begin
                            out_data_r <= sum_w;
                            out_sat_r  <= flag_w;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = out_data_r;
    assign bus.out_sat   = out_sat_r;
    assign busy          = (state != IDLE);

endmodule

// File: doc/accum_sat_stage.md
ACCUM_SAT_STAGE -- requirements
Module: accum_sat_stage

Interface
REQ-001 SHALL have parameter N, default 8, sample and accumulator width, signed two's complement.
REQ-002 SHALL have parameter CNT_W, default 8, width of the block-length field.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  begin a block; honoured only in IDLE.
REQ-006 SHALL have port len  input  CNT_W  number of samples in the block; sampled on an accepted start.
REQ-007 SHALL have port in_valid  input  1  upstream sample valid.
REQ-008 SHALL have port in_ready  output  1  stage accepts a sample.
REQ-009 SHALL have port in_data  input  N  signed sample from the upstream add/subtract stage.
REQ-010 SHALL have port in_ovf  input  1  upstream overflow flag qualifying in_data.
REQ-011 SHALL have port out_valid  output  1  block result valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port out_data  output  N  saturated block sum.
REQ-014 SHALL have port out_sat  output  1  a clamp or an upstream overflow occurred within the block.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, ACCUM and DONE.
REQ-017 In IDLE, when start=1 and len!=0, the block SHALL clear the accumulator and sticky flag, load the counter with len, and enter ACCUM on the next cycle.
REQ-018 In IDLE, start with len=0 SHALL be ignored; state, counter and outputs SHALL remain unchanged.
REQ-019 start SHALL be ignored in ACCUM and DONE.
REQ-020 in_ready SHALL be 1 only in ACCUM, driven from state only, with no combinational path from in_valid.
REQ-021 A sample beat SHALL be accepted when in_valid and in_ready are both 1 on a clock edge; in_data and in_ovf are ignored otherwise.
REQ-022 On each accepted beat, the block SHALL form the N+1-bit sum acc+in_data.
REQ-023 If that sum exceeds 2^(N-1)-1, acc SHALL clamp to 2^(N-1)-1; if it is below -2^(N-1), acc SHALL clamp to -2^(N-1); otherwise acc SHALL take the sum.
REQ-024 On an accepted beat, the sticky flag SHALL OR in (clamp occurred) | in_ovf.
REQ-025 The counter SHALL decrement by 1 on each accepted beat.
REQ-026 The beat that decrements the counter from 1 SHALL move the FSM to DONE on the next cycle.
REQ-027 out_valid SHALL assert exactly one cycle after the final accepted beat.
REQ-028 In DONE, out_valid SHALL be 1 and out_data/out_sat SHALL be registered values held stable until out_valid and out_ready are both 1.
REQ-029 On an output handshake the FSM SHALL return to IDLE; out_valid SHALL drop the next cycle.
REQ-030 A start asserted in the same cycle as the output handshake SHALL be ignored; a new block requires start in IDLE.
REQ-031 After clamping, accumulation SHALL continue from the clamped value, with no wrap-around.
REQ-032 The block SHALL NOT assert in_ready and out_valid in the same cycle.

Reset
REQ-033 While rst_n=0, the block SHALL asynchronously force state=IDLE, acc=0, counter=0, sticky=0, out_valid=0, out_data=0, out_sat=0, in_ready=0 and busy=0.
REQ-034 A reset asserted mid-block SHALL discard partial results; no out_valid SHALL follow the deassertion of reset.
REQ-035 Deassertion of reset SHALL take effect on the next rising clk edge; the first start is honoured on that edge or later.

Structure
REQ-036 The FSM state enum and the saturation limit constants, as functions of N, SHALL reside in shared package accum_pkg.
REQ-037 Saturating addition SHALL be one combinational sub-module sat_add, with ports a[N-1:0], b[N-1:0], sum[N-1:0], clamp.
REQ-038 The FSM, counter and output registers SHALL reside in accum_sat_stage.

Verification (N=8, CNT_W=8)
REQ-039 Stimulus: start, len=3, then samples 10, -4, 7 with in_valid continuously high. Required response: out_data=13, out_sat=0, out_valid one cycle after the third beat.
REQ-040 Stimulus: len=2, samples 100 and 100. Required response: out_data=127, out_sat=1. Stimulus: len=2, samples -100 and -100. Required response: out_data=-128, out_sat=1.
REQ-041 Stimulus: len=3, samples 120, 20, -50. Required response: out_data=77, because accumulation resumes from the clamped value 127, and out_sat=1.
REQ-042 Stimulus: len=2, samples 1 and 2 with in_ovf=1 on the second beat, and in_valid toggled randomly. Required response: out_data=3, out_sat=1, and exactly 2 beats accepted.
REQ-043 Stimulus: out_ready held low for 5 cycles while in DONE, with start pulsed. Required response: out_data held stable, start ignored, busy=1; IDLE one cycle after out_ready rises.
REQ-044 Stimulus: start with len=0. Required response: remains in IDLE. Stimulus: rst_n pulsed low after 1 of 4 beats. Required response: all outputs 0 immediately, no out_valid follows.
